// File: rtl/ysyx_22041412_wb_pkg.sv
// rtl/ysyx_22041412_wb_pkg.sv - shared types and widths for the writeback unit
package ysyx_22041412_wb_pkg;

  localparam int XLEN_DEF = 64;
  localparam int RIDX_W   = 5;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2,
    SRC_MDU  = 2'd3
  } src_e;

endpackage

// File: rtl/ysyx_22041412_scoreboard.sv
// rtl/ysyx_22041412_scoreboard.sv - pending-write bits for long-latency destinations
module ysyx_22041412_scoreboard
  import ysyx_22041412_wb_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [RIDX_W-1:0] set_rd,
  input  logic              clr_en,
  input  logic [RIDX_W-1:0] clr_rd,
  input  logic [RIDX_W-1:0] rs1,
  input  logic [RIDX_W-1:0] rs2,
  input  logic [RIDX_W-1:0] rd,
  output logic              pend_rs1,
  output logic              pend_rs2,
  output logic              pend_rd
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] one;

  assign one      = {{(NREG-1){1'b0}}, 1'b1};
  assign set_mask = set_en ? (one << set_rd) : '0;
  assign clr_mask = clr_en ? (one << clr_rd) : '0;

  // Set is applied after clear so a same-cycle reissue keeps the bit; x0 never pends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~clr_mask) | set_mask) & ~one;
    end
  end

  assign pend_rs1 = (rs1 != '0) & pending[rs1];
  assign pend_rs2 = (rs2 != '0) & pending[rs2];
  assign pend_rd  = (rd  != '0) & pending[rd];

endmodule

// File: rtl/ysyx_22041412_wbu.sv
// rtl/ysyx_22041412_wbu.sv - writeback arbiter, hazard scoreboard, operand select
// Optional forwarding from the wb register: YSYX_22041412_WB_BYPASS_EN
module ysyx_22041412_wbu
  import ysyx_22041412_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic              iss_long,
  input  logic [RIDX_W-1:0] iss_rd,
  input  logic [RIDX_W-1:0] rs1,
  input  logic [RIDX_W-1:0] rs2,
  output logic              hz_rs1,
  output logic              hz_rs2,
  output logic              hz_rd,
  input  logic [XLEN-1:0]   rf_rdata_a,
  input  logic [XLEN-1:0]   rf_rdata_b,
  output logic [XLEN-1:0]   opa,
  output logic [XLEN-1:0]   opb,
  input  logic              alu_valid,
  input  logic [RIDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [RIDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [RIDX_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]   mdu_data,
  output logic              wb_wen,
  output logic [RIDX_W-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data
);

  src_e              sel;
  logic [RIDX_W-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;
  logic              pend_rs1, pend_rs2;
  logic              fwd_rs1, fwd_rs2;

  assign lsu_ready = rst & ~alu_valid;
  assign mdu_ready = rst & ~alu_valid & ~lsu_valid;

  always_comb begin
    sel      = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (alu_valid) begin
      sel = SRC_ALU;  sel_rd = alu_rd;  sel_data = alu_data;
    end else if (lsu_valid && lsu_ready) begin
      sel = SRC_LSU;  sel_rd = lsu_rd;  sel_data = lsu_data;
    end else if (mdu_valid && mdu_ready) begin
      sel = SRC_MDU;  sel_rd = mdu_rd;  sel_data = mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_wen  <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      wb_wen  <= (sel != SRC_NONE) && (sel_rd != '0);
      wb_rd   <= sel_rd;
      wb_data <= sel_data;
    end
  end

  ysyx_22041412_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_valid & iss_long & (iss_rd != '0)),
    .set_rd   (iss_rd),
    .clr_en   (rst & ((sel == SRC_LSU) | (sel == SRC_MDU))),
    .clr_rd   (sel_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (iss_rd),
    .pend_rs1 (pend_rs1),
    .pend_rs2 (pend_rs2),
    .pend_rd  (hz_rd)
  );

  // A result sitting in the wb register has not reached the register file yet.
  assign fwd_rs1 = wb_wen && (wb_rd == rs1) && (rs1 != '0);
  assign fwd_rs2 = wb_wen && (wb_rd == rs2) && (rs2 != '0);

`ifdef YSYX_22041412_WB_BYPASS_EN
  assign opa    = fwd_rs1 ? wb_data : rf_rdata_a;
  assign opb    = fwd_rs2 ? wb_data : rf_rdata_b;
  assign hz_rs1 = pend_rs1;
  assign hz_rs2 = pend_rs2;
`else
  assign opa    = rf_rdata_a;
  assign opb    = rf_rdata_b;
  assign hz_rs1 = pend_rs1 | fwd_rs1;
  assign hz_rs2 = pend_rs2 | fwd_rs2;
`endif

endmodule

// File: tb/tb_ysyx_22041412_wbu.sv
// tb/tb_ysyx_22041412_wbu.sv - randomized model-checked bench for the writeback unit
module tb_ysyx_22041412_wbu;

  logic        clk, rst;
  logic        iss_valid, iss_long;
  logic [4:0]  iss_rd, rs1, rs2;
  logic        hz_rs1, hz_rs2, hz_rd;
  logic [63:0] rf_rdata_a, rf_rdata_b, opa, opb;
  logic        alu_valid, lsu_valid, lsu_ready, mdu_valid, mdu_ready;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd;
  logic [63:0] alu_data, lsu_data, mdu_data;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  int checks = 0;
  int errors = 0;

`ifdef YSYX_22041412_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Reference state: which registers await a long result, and what the write port holds.
  bit [31:0] m_pend;
  bit        m_wen;
  bit [4:0]  m_rd;
  bit [63:0] m_data;

  ysyx_22041412_wbu dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2),
    .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_rd(hz_rd),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .opa(opa), .opb(opb),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_long = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    rf_rdata_a = 0; rf_rdata_b = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
  endtask

  function automatic bit inflight(input logic [4:0] r);
    return m_wen && (m_rd == r) && (r != 0);
  endfunction

  // Compare all outputs against the reference, then advance the reference with the clock edge.
  task automatic tick();
    bit        n_wen, clr, any;
    bit [4:0]  n_rd;
    bit [63:0] n_data;
    bit [31:0] n_pend;
    #4;
    chk("lsu_ready", lsu_ready, rst && !alu_valid);
    chk("mdu_ready", mdu_ready, rst && !alu_valid && !lsu_valid);
    chk("hz_rs1", hz_rs1, (rs1 != 0 && m_pend[rs1]) || (!BYP && inflight(rs1)));
    chk("hz_rs2", hz_rs2, (rs2 != 0 && m_pend[rs2]) || (!BYP && inflight(rs2)));
    chk("hz_rd", hz_rd, iss_rd != 0 && m_pend[iss_rd]);
    chk("opa", opa, (BYP && inflight(rs1)) ? m_data : rf_rdata_a);
    chk("opb", opb, (BYP && inflight(rs2)) ? m_data : rf_rdata_b);
    chk("wb_wen", wb_wen, m_wen);
    if (m_wen) begin
      chk("wb_rd", wb_rd, m_rd);
      chk("wb_data", wb_data, m_data);
    end
    any = 1; clr = 0; n_rd = 0; n_data = 0;
    if (alu_valid)      begin n_rd = alu_rd; n_data = alu_data; end
    else if (lsu_valid) begin n_rd = lsu_rd; n_data = lsu_data; clr = 1; end
    else if (mdu_valid) begin n_rd = mdu_rd; n_data = mdu_data; clr = 1; end
    else any = 0;
    n_pend = m_pend;
    if (clr) n_pend[n_rd] = 1'b0;
    if (iss_valid && iss_long && iss_rd != 0) n_pend[iss_rd] = 1'b1;
    n_wen = any && n_rd != 0;
    if (!rst) begin
      n_pend = 0; n_wen = 0; n_rd = 0; n_data = 0;
    end
    @(posedge clk);
    m_pend = n_pend; m_wen = n_wen; m_rd = n_rd; m_data = n_data;
    #1;
  endtask

  initial begin
    idle();
    rst = 0;
    m_pend = 0; m_wen = 0; m_rd = 0; m_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset wb_wen", wb_wen, 0);
    chk("reset wb_rd", wb_rd, 0);
    chk("reset wb_data", wb_data, 0);
    chk("reset lsu_ready", lsu_ready, 0);
    chk("reset mdu_ready", mdu_ready, 0);
    rst = 1;

    // ALU write lands one cycle later
    alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
    tick(); idle(); #1;
    chk("alu wen", wb_wen, 1);
    chk("alu rd", wb_rd, 5);
    chk("alu data", wb_data, 64'h1234);

    // three-way contention drains in priority order
    alu_valid = 1; alu_rd = 3; alu_data = 64'h33;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 64'h44;
    mdu_valid = 1; mdu_rd = 6; mdu_data = 64'h66;
    #1;
    chk("cont lsu_ready", lsu_ready, 0);
    chk("cont mdu_ready", mdu_ready, 0);
    tick(); alu_valid = 0; #1;
    chk("cont 1st rd", wb_rd, 3);
    chk("cont mdu_ready wait", mdu_ready, 0);
    tick(); lsu_valid = 0; #1;
    chk("cont 2nd rd", wb_rd, 4);
    chk("cont 2nd data", wb_data, 64'h44);
    tick(); mdu_valid = 0; #1;
    chk("cont 3rd rd", wb_rd, 6);
    chk("cont 3rd data", wb_data, 64'h66);

    // long op to x10 holds hazard until its load result is captured
    tick();
    iss_valid = 1; iss_long = 1; iss_rd = 10;
    tick(); idle(); rs1 = 10; #1;
    chk("long hz held", hz_rs1, 1);
    tick(); tick();
    chk("long hz held 2", hz_rs1, 1);
    lsu_valid = 1; lsu_rd = 10; lsu_data = 64'hBEEF;
    tick(); lsu_valid = 0; #1;
    chk("long hz after capture", hz_rs1, BYP ? 0 : 1);
    tick();
    chk("long hz released", hz_rs1, 0);

    // result in wb register seen by decode
    alu_valid = 1; alu_rd = 7; alu_data = 64'hAA;
    tick(); idle(); rs2 = 7; rf_rdata_b = 64'h55; #1;
    chk("wb fwd opb", opb, BYP ? 64'hAA : 64'h55);
    chk("wb fwd hz_rs2", hz_rs2, BYP ? 0 : 1);

    // x0 never written
    tick();
    alu_valid = 1; alu_rd = 0; alu_data = 64'h99;
    tick(); idle(); #1;
    chk("x0 wen", wb_wen, 0);

    // same-cycle set and clear on x9 keeps the bit
    iss_valid = 1; iss_long = 1; iss_rd = 9;
    tick();
    lsu_valid = 1; lsu_rd = 9; lsu_data = 64'h9;
    tick(); idle(); rs1 = 9;
    tick(); #1;
    chk("set beats clear", hz_rs1, 1);

    // reset clears pending bits and drops a result offered during reset
    iss_valid = 1; iss_long = 1; iss_rd = 12;
    tick(); idle();
    rst = 0; alu_valid = 1; alu_rd = 5; alu_data = 64'h77; lsu_valid = 1; #1;
    chk("rst lsu_ready", lsu_ready, 0);
    tick(); idle(); rst = 1;
    rs1 = 9; rs2 = 12; iss_rd = 9; #1;
    chk("rst hz_rs1", hz_rs1, 0);
    chk("rst hz_rs2", hz_rs2, 0);
    chk("rst hz_rd", hz_rd, 0);
    chk("rst wb_wen", wb_wen, 0);
    chk("rst wb_rd", wb_rd, 0);
    chk("rst wb_data", wb_data, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 99) != 0);
      iss_valid  = $urandom_range(0, 1);
      iss_long   = $urandom_range(0, 1);
      iss_rd     = 5'($urandom_range(0, 11));
      rs1        = 5'($urandom_range(0, 11));
      rs2        = 5'($urandom_range(0, 11));
      rf_rdata_a = {$urandom, $urandom};
      rf_rdata_b = {$urandom, $urandom};
      alu_valid  = ($urandom_range(0, 3) == 0);
      alu_rd     = 5'($urandom_range(0, 11));
      alu_data   = {$urandom, $urandom};
      lsu_valid  = $urandom_range(0, 1);
      lsu_rd     = 5'($urandom_range(0, 11));
      lsu_data   = {$urandom, $urandom};
      mdu_valid  = $urandom_range(0, 1);
      mdu_rd     = 5'($urandom_range(0, 11));
      mdu_data   = {$urandom, $urandom};
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
